// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipelined MIPS core.
//   word_t       : 32-bit machine word
//   fetchState_t : fetch stage run/halt state
//   NOP_INS      : encoding placed in IF/ID for a bubble (sll $0,$0,0)
//   pc_plus4     : 32-bit modulo PC increment
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetchState_t;

  localparam word_t NOP_INS = 32'h0000_0000;

  function automatic word_t pc_plus4(input word_t p);
    return p + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: icache read port, downstream control and the
// IF/ID latch outputs.
//   modport fu : seen from the fetch unit
//   modport tb : seen from the environment (icache + decode side)
interface fetch_unit_if;
  import cpu_types_pkg::*;

  // icache side
  logic  ihit;
  word_t iload;
  logic  iREN;
  word_t iaddr;
  // downstream control
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  // IF/ID latch
  word_t ins;
  word_t npc;
  logic  ins_valid;

  modport fu (
    input  ihit, iload, stall, redirect, redirect_pc, halt,
    output iREN, iaddr, ins, npc, ins_valid
  );

  modport tb (
    output ihit, iload, stall, redirect, redirect_pc, halt,
    input  iREN, iaddr, ins, npc, ins_valid
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer holding a fetched word and its PC+4.
//   clk, rst     : clock, synchronous active-high reset
//   load         : capture d_word/d_npc, mark valid
//   drain        : entry consumed, mark empty
//   clear        : discard entry (redirect/halt)
//   d_word/d_npc : incoming word and its PC+4
//   q_word/q_npc : stored word and its PC+4
//   valid        : entry holds a word
module fetch_skid_buffer
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  drain,
  input  logic  clear,
  input  word_t d_word,
  input  word_t d_npc,
  output word_t q_word,
  output word_t q_npc,
  output logic  valid
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid  <= 1'b0;
      q_word <= '0;
      q_npc  <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      q_word <= d_word;
      q_npc  <= d_npc;
    end else if (drain) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the icache, and fills the
// IF/ID latch feeding decode. Downstream stalls are absorbed by a one-entry
// skid buffer; redirects and halt override everything but reset.
//   CLK, RST : clock, synchronous active-high reset
//   fuif     : fetch_unit_if.fu (icache read port, stall/redirect/halt,
//              IF/ID outputs ins/npc/ins_valid)
//   PC_INIT  : PC loaded on reset
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic      CLK,
  input  logic      RST,
  fetch_unit_if.fu  fuif
);

  fetchState_t state_q;
  word_t       pc_q;
  word_t       ins_q;
  word_t       npc_q;
  logic        insv_q;

  word_t       pc_next4;
  logic        run;
  logic        iren;
  logic        accept;
  logic        buf_load;
  logic        buf_drain;
  logic        buf_clear;
  word_t       buf_word;
  word_t       buf_npc;
  logic        buf_valid;

  assign pc_next4 = pc_plus4(pc_q);

  always_comb begin
    run    = (state_q == RUN);
    // No new request while a word is parked; halt blocks in its own cycle.
    iren   = run && !buf_valid && !fuif.halt;
    accept = fuif.ihit && iren && !fuif.redirect;
    // Buffer control mirrors the priority chain in the register block below.
    buf_clear = run && (fuif.halt || fuif.redirect);
    buf_load  = run && !fuif.halt && !fuif.redirect && fuif.stall && accept;
    buf_drain = run && !fuif.halt && !fuif.redirect && !fuif.stall && buf_valid;
  end

  fetch_skid_buffer u_skid (
    .clk    (CLK),
    .rst    (RST),
    .load   (buf_load),
    .drain  (buf_drain),
    .clear  (buf_clear),
    .d_word (fuif.iload),
    .d_npc  (pc_next4),
    .q_word (buf_word),
    .q_npc  (buf_npc),
    .valid  (buf_valid)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      pc_q    <= PC_INIT;
      ins_q   <= NOP_INS;
      npc_q   <= '0;
      insv_q  <= 1'b0;
    end else if (state_q == HALTED) begin
      // Frozen until reset; IF/ID already holds a bubble.
      ins_q   <= NOP_INS;
      insv_q  <= 1'b0;
    end else if (fuif.halt) begin
      state_q <= HALTED;
      ins_q   <= NOP_INS;
      insv_q  <= 1'b0;
    end else if (fuif.redirect) begin
      pc_q    <= fuif.redirect_pc & ~32'd3;
      ins_q   <= NOP_INS;
      insv_q  <= 1'b0;
    end else if (fuif.stall) begin
      // IF/ID held; an accepted word is parked in the skid buffer.
      if (accept) pc_q <= pc_next4;
    end else if (buf_valid) begin
      ins_q   <= buf_word;
      npc_q   <= buf_npc;
      insv_q  <= 1'b1;
    end else if (accept) begin
      pc_q    <= pc_next4;
      ins_q   <= fuif.iload;
      npc_q   <= pc_next4;
      insv_q  <= 1'b1;
    end else begin
      ins_q   <= NOP_INS;
      insv_q  <= 1'b0;
    end
  end

  assign fuif.iREN      = iren;
  assign fuif.iaddr     = pc_q;
  assign fuif.ins       = ins_q;
  assign fuif.npc       = npc_q;
  assign fuif.ins_valid = insv_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic CLK = 1'b0;
  logic RST;
  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_unit_if fif ();

  fetch_unit #(.PC_INIT(32'h0000_0040)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .fuif (fif)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] npc,
                          input logic v);
    chk({tag, ".ins"}, fif.ins, ins);
    chk({tag, ".npc"}, fif.npc, npc);
    chk({tag, ".valid"}, {31'd0, fif.ins_valid}, {31'd0, v});
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] addr, input logic ren);
    #1;
    chk({tag, ".iaddr"}, fif.iaddr, addr);
    chk({tag, ".iREN"}, {31'd0, fif.iREN}, {31'd0, ren});
  endtask

  initial begin
    RST = 1'b1;
    fif.ihit = 1'b0; fif.iload = '0; fif.stall = 1'b0;
    fif.redirect = 1'b0; fif.redirect_pc = '0; fif.halt = 1'b0;

    // reset state
    step();
    chk_ifid("reset", 32'h0, 32'h0, 1'b0);
    chk_fetch("reset", 32'h40, 1'b1);

    // back-to-back hits
    RST = 1'b0; fif.ihit = 1'b1; fif.iload = 32'h1111_0040;
    step();
    chk_ifid("seq0", 32'h1111_0040, 32'h44, 1'b1);
    fif.iload = 32'h1111_0044;
    chk_fetch("seq0", 32'h44, 1'b1);
    step();
    chk_ifid("seq1", 32'h1111_0044, 32'h48, 1'b1);

    // stall for 3 cycles, one word captured
    fif.stall = 1'b1; fif.iload = 32'hAAAA_0001;
    chk_fetch("stall_in", 32'h48, 1'b1);
    step();
    chk_ifid("stall1", 32'h1111_0044, 32'h48, 1'b1);
    fif.iload = 32'hBBBB_0002;
    chk_fetch("stall1", 32'h4C, 1'b0);
    step();
    chk_ifid("stall2", 32'h1111_0044, 32'h48, 1'b1);
    chk_fetch("stall2", 32'h4C, 1'b0);
    step();
    chk_ifid("stall3", 32'h1111_0044, 32'h48, 1'b1);
    fif.stall = 1'b0; fif.iload = 32'hBBBB_0003;
    chk_fetch("release", 32'h4C, 1'b0);
    step();
    chk_ifid("drain", 32'hAAAA_0001, 32'h4C, 1'b1);
    fif.iload = 32'h1111_004C;
    chk_fetch("drain", 32'h4C, 1'b1);
    step();
    chk_ifid("resume", 32'h1111_004C, 32'h50, 1'b1);

    // redirect with simultaneous hit
    fif.redirect = 1'b1; fif.redirect_pc = 32'h0000_1003; fif.iload = 32'hDEAD_0001;
    step();
    chk_ifid("redir", 32'h0, 32'h50, 1'b0);
    fif.redirect = 1'b0; fif.iload = 32'h2222_1000;
    chk_fetch("redir", 32'h1000, 1'b1);
    step();
    chk_ifid("redir_tgt", 32'h2222_1000, 32'h1004, 1'b1);

    // redirect beats stall
    fif.redirect = 1'b1; fif.redirect_pc = 32'h0000_2002; fif.stall = 1'b1;
    fif.iload = 32'hDEAD_0002;
    step();
    chk_ifid("redir_st", 32'h0, 32'h1004, 1'b0);
    fif.redirect = 1'b0; fif.stall = 1'b0; fif.iload = 32'h2222_2000;
    chk_fetch("redir_st", 32'h2000, 1'b1);
    step();
    chk_ifid("redir_st_tgt", 32'h2222_2000, 32'h2004, 1'b1);

    // PC wrap
    fif.redirect = 1'b1; fif.redirect_pc = 32'hFFFF_FFFC; fif.ihit = 1'b0;
    step();
    fif.redirect = 1'b0; fif.ihit = 1'b1; fif.iload = 32'h3333_0FFC;
    chk_fetch("wrap_pc", 32'hFFFF_FFFC, 1'b1);
    step();
    chk_ifid("wrap", 32'h3333_0FFC, 32'h0, 1'b1);
    chk_fetch("wrap", 32'h0, 1'b1);

    // reset mid-stall with a parked word
    fif.stall = 1'b1; fif.iload = 32'hCCCC_0001;
    step();
    chk_fetch("park", 32'h4, 1'b0);
    RST = 1'b1;
    step();
    chk_ifid("rst_mid", 32'h0, 32'h0, 1'b0);
    RST = 1'b0; fif.stall = 1'b0; fif.ihit = 1'b0;
    chk_fetch("rst_mid", 32'h40, 1'b1);
    step();
    chk_ifid("rst_after", 32'h0, 32'h0, 1'b0);
    chk_fetch("rst_after", 32'h40, 1'b1);

    // halt, then ignored redirect
    fif.ihit = 1'b1; fif.iload = 32'h4444_0040;
    step();
    chk_ifid("pre_halt", 32'h4444_0040, 32'h44, 1'b1);
    fif.halt = 1'b1; fif.iload = 32'h4444_0044;
    chk_fetch("halt_in", 32'h44, 1'b0);
    step();
    chk_ifid("halted", 32'h0, 32'h44, 1'b0);
    fif.halt = 1'b0; fif.redirect = 1'b1; fif.redirect_pc = 32'h0000_3000;
    chk_fetch("halted", 32'h44, 1'b0);
    step();
    chk_ifid("halt_redir", 32'h0, 32'h44, 1'b0);
    chk_fetch("halt_redir", 32'h44, 1'b0);
    fif.redirect = 1'b0;
    step();
    chk_fetch("halt_hold", 32'h44, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core, directly upstream of the decode unit. It owns the PC and issues instruction reads to the instruction cache. It holds the fetched word in the IF/ID latch that drives the decode unit's `ins` input. It also absorbs decode/hazard stalls with a one-entry skid buffer, and applies branch/jump redirects and halt.

## Interface
Parameters:
- `PC_INIT`, `32'h0000_0000`, PC value loaded on reset.

Ports:
- `CLK`  in  1  core clock; all state updates on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `ihit`  in  1  icache returns valid `iload` this cycle for `iaddr`.
- `iload`  in  32 (`word_t`)  instruction word from icache.
- `iREN`  out  1  instruction read request.
- `iaddr`  out  32 (`word_t`)  read address, always equal to current PC.
- `stall`  in  1  downstream cannot accept; hold the IF/ID latch.
- `redirect`  in  1  taken branch/jump resolved downstream.
- `redirect_pc`  in  32 (`word_t`)  target PC; bits [1:0] ignored (treated as 0).
- `halt`  in  1  decode has a valid halt; stop fetching.
- `ins`  out  32 (`word_t`)  IF/ID instruction to decode.
- `npc`  out  32 (`word_t`)  IF/ID PC+4 of `ins`.
- `ins_valid`  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- States (`fetchState_t`): `RUN`, `HALTED`.
  - `RUN` → `HALTED` when `halt`=1.
  - `HALTED` exits only via `RST`.
- Registers: `pc`, `buf`/`buf_valid` (skid entry), IF/ID (`ins`, `npc`, `ins_valid`), state.
- `iaddr = pc`. `iREN = (state==RUN) && !buf_valid && !halt`.
- Accepted fetch: `ihit && iREN && !redirect`. On acceptance, `pc <= pc + 4`.
- Per-cycle priority, highest first:
  1. `RST`: `pc<=PC_INIT`, `buf_valid<=0`, IF/ID bubble, state `RUN`.
  2. `halt`: state `HALTED`, IF/ID bubble, `buf_valid<=0`, `pc` frozen.
  3. `redirect`:
     - `pc<=redirect_pc & ~3`, `buf_valid<=0`, IF/ID bubble.
     - Any `ihit` this cycle is discarded.
     - Overrides `stall`.
  4. `stall`:
     - IF/ID held unchanged.
     - An accepted fetch goes into `buf` (`buf_valid<=1`).
     - `iREN` is low while `buf_valid`=1, so at most one word is captured.
  5. No stall, `buf_valid`=1: IF/ID `<= {buf, buf_pc+4, 1}`, `buf_valid<=0`. No fetch is issued that cycle.
  6. No stall, accepted fetch: IF/ID `<= {iload, pc+4, 1}`.
  7. No stall, no word available: IF/ID bubble.
- Bubble encoding: `ins=32'h0` (sll nop), `ins_valid=0`, `npc` unchanged.
- Arithmetic: PC+4 is 32-bit modulo; `32'hFFFF_FFFC + 4 = 0`.
- `buf` stores its own PC+4 so `npc` stays correct across stalls.
- In `HALTED`:
  - `iREN=0`; the PC does not change.
  - `ins_valid=0`.
  - `stall` and `redirect` are ignored.

## Timing
- Reset values: `pc=PC_INIT`, `iREN=1` (first cycle after reset), `iaddr=PC_INIT`, `ins=0`, `npc=0`, `ins_valid=0`, `buf_valid=0`, state `RUN`.
- Latency: `ihit` in cycle N → `ins`/`ins_valid` visible cycle N+1 (no stall).
- Throughput: one instruction per cycle on back-to-back hits.
- Stall release: buffered word appears the cycle after `stall` falls. Fetching resumes that same cycle (`iREN` high again).
- Redirect: first target fetch request is issued in cycle N+1 and reaches IF/ID no earlier than N+2.
- `ihit` while `iREN`=0 is ignored.

## Structure
- `word_t` comes from `cpu_types_pkg`.
- Add `fetchState_t` (`RUN`, `HALTED`) and the `NOP_INS` constant to `cpu_types_pkg`.
- Add interface `fetch_unit_if` with modport `fu`.
- Natural sub-module: `fetch_skid_buffer`, a one-entry word+PC buffer with load/drain/clear.

## Test plan
- Reset with `PC_INIT=0x40`, `ihit`=1 every cycle:
  - `iaddr` = 0x40, 0x44, 0x48 on successive cycles.
  - `npc` = 0x44, 0x48, … one cycle behind.
  - `ins_valid`=1 from cycle 2.
- `ihit`=1 with `iload`=0xAAAA0001 while `stall`=1 for 3 cycles:
  - IF/ID is frozen.
  - `iREN` drops after one capture.
  - On release, `ins`=0xAAAA0001 with correct `npc`, then the next fetch proceeds.
- `redirect`=1, `redirect_pc`=0x1003, with `ihit` the same cycle:
  - Fetched word is dropped; IF/ID goes to bubble.
  - Next `iaddr`=0x1000.
  - Repeat with `stall`=1 in the same cycle: the redirect must still win.
- `halt`=1 in cycle N: from N+1, `iREN`=0, `ins_valid`=0 and `iaddr` is frozen. A later `redirect` has no effect.
- PC wrap: `redirect_pc`=0xFFFFFFFC then a hit → `npc`=0x0, next `iaddr`=0x0.
- `RST` asserted mid-stall with `buf_valid`=1:
  - Next cycle all outputs are at reset values and `buf_valid`=0.
  - The buffered word never appears on `ins`.
